// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush event counters.
module if_id_hazard_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_plus4_in,
  input  logic [31:0]      instr_in,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ctrl_bubble,
  output logic [31:0]      if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rs;
  logic       uses_rt;
  logic       hazard;
  logic       flush;
  logic       stall;

  assign op = if_id_instr[31:26];
  assign rs = if_id_instr[25:21];
  assign rt = if_id_instr[20:16];

  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  assign uses_rs = (op != OP_J);

  // A load targeting $0 never produces a value anyone waits on.
  always_comb begin
    hazard = 1'b0;
    if (if_id_valid && id_ex_mem_read && (id_ex_rt != 5'd0)) begin
      hazard = (uses_rs && (rs == id_ex_rt)) || (uses_rt && (rt == id_ex_rt));
    end
  end

  // Flush wins over a stall: the load in EX is itself on the wrong path.
  assign flush       = branch_taken;
  assign stall       = hazard && !branch_taken;
  assign pc_write    = !stall;
  assign ctrl_bubble = flush || hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_pc_plus4 <= '0;
      if_id_instr    <= '0;
      if_id_valid    <= 1'b0;
    end else if (flush) begin
      if_id_pc_plus4 <= '0;
      if_id_instr    <= '0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_pc_plus4 <= pc_plus4_in;
      if_id_instr    <= instr_in;
      if_id_valid    <= 1'b1;
    end
  end

  // Counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule
